// File: rtl/key_event_multi.sv
// Multi-key debouncer and single/double/long click classifier on a shared ms tick.
// Define KEY_AUTO_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event_multi #(
    parameter int NUM_KEYS    = 4,
    parameter int TICK_CYCLES = 24000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter int DCLICK_MS   = 100,
    parameter int REPEAT_MS   = 200,
    parameter int CNT_W       = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] ev_single,
    output logic [NUM_KEYS-1:0] ev_double,
    output logic [NUM_KEYS-1:0] ev_long,
    output logic [NUM_KEYS-1:0] ev_repeat,
    output logic [NUM_KEYS-1:0] key_level
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    if (DEBOUNCE_MS < 1 || LONG_MS >= 2**CNT_W || DCLICK_MS >= 2**CNT_W ||
        REPEAT_MS >= 2**CNT_W || DEBOUNCE_MS >= 2**CNT_W) begin : g_cfg_err
        $error("key_event_multi: timing parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, PRESS1, LONG, GAP, PRESS2} state_t;

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

`ifndef KEY_AUTO_REPEAT_EN
    assign ev_repeat = '0;
`endif

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             s1, s2, synced, stable, accept, press, rel;
        logic [DW-1:0]    dcnt;
        logic [CNT_W-1:0] cnt;
        logic             sgl, dbl, lng;
        state_t           state;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
            end else begin
                s1 <= key_n[g];
                s2 <= s1;
            end
        end

        assign synced = ~s2;
        assign accept = (synced != stable) && tick &&
                        (dcnt == DW'(DEBOUNCE_MS - 1));
        assign press  = accept & synced;
        assign rel    = accept & ~synced;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stable <= 1'b0;
                dcnt   <= '0;
            end else if (synced == stable) begin
                dcnt <= '0;
            end else if (tick) begin
                if (accept) begin
                    stable <= synced;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

`ifdef KEY_AUTO_REPEAT_EN
        logic rpt;
        assign ev_repeat[g] = rpt;
`endif

        // Counter compares use the pre-increment value, so a press on the
        // same cycle as the tick that would expire the gap still counts.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                sgl   <= 1'b0;
                dbl   <= 1'b0;
                lng   <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                rpt   <= 1'b0;
`endif
            end else begin
                sgl <= 1'b0;
                dbl <= 1'b0;
                lng <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                rpt <= 1'b0;
`endif
                if (tick && cnt != '1)
                    cnt <= cnt + 1'b1;
                unique case (state)
                    IDLE: begin
                        if (press) begin
                            state <= PRESS1;
                            cnt   <= '0;
                        end
                    end
                    PRESS1: begin
                        if (rel) begin
                            state <= GAP;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(LONG_MS)) begin
                            lng   <= 1'b1;
                            state <= LONG;
                            cnt   <= '0;
                        end
                    end
                    LONG: begin
                        if (rel) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
`ifdef KEY_AUTO_REPEAT_EN
                        else if (cnt == CNT_W'(REPEAT_MS)) begin
                            rpt <= 1'b1;
                            cnt <= '0;
                        end
`endif
                    end
                    GAP: begin
                        if (press && cnt < CNT_W'(DCLICK_MS)) begin
                            dbl   <= 1'b1;
                            state <= PRESS2;
                            cnt   <= '0;
                        end else if (cnt == CNT_W'(DCLICK_MS)) begin
                            sgl   <= 1'b1;
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    PRESS2: begin
                        if (rel) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign ev_single[g] = sgl;
        assign ev_double[g] = dbl;
        assign ev_long[g]   = lng;
        assign key_level[g] = stable;
    end

endmodule

// File: tb/tb_key_event_multi.sv
// Randomised bench for key_event_multi: timestamp-based reference model plus scenario counts.
module tb_key_event_multi;
    localparam int NK  = 2;
    localparam int TC  = 10;
    localparam int DEB = 3;
    localparam int LMS = 50;
    localparam int DMS = 20;
    localparam int RMS = 10;
    localparam int CW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] ev_single, ev_double, ev_long, ev_repeat, key_level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    key_event_multi #(
        .NUM_KEYS(NK), .TICK_CYCLES(TC), .DEBOUNCE_MS(DEB), .LONG_MS(LMS),
        .DCLICK_MS(DMS), .REPEAT_MS(RMS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .ev_single(ev_single), .ev_double(ev_double), .ev_long(ev_long),
        .ev_repeat(ev_repeat), .key_level(key_level)
    );

    // Reference: elapsed ms measured as tick timestamps since phase entry.
    typedef enum {M_IDLE, M_DOWN, M_HOLD, M_WAIT, M_DOWN2} phase_t;
    phase_t        ph[NK];
    int            run[NK], ent[NK];
    bit            lvl[NK], q1[NK], q2[NK];
    int            k, t_now;
    logic [NK-1:0] m_s, m_d, m_l, m_r, m_lvl;

    always @(posedge clk) begin
        bit tk, syn, pr, rl;
        int el, tn;
        m_s = '0; m_d = '0; m_l = '0; m_r = '0;
        if (rst) begin
            k = 0; t_now = 0; m_lvl = '0;
            for (int i = 0; i < NK; i++) begin
                ph[i] = M_IDLE; run[i] = 0; ent[i] = 0;
                lvl[i] = 0; q1[i] = 1; q2[i] = 1;
            end
        end else begin
            tk = ((k % TC) == TC - 1);
            k++;
            tn = t_now + (tk ? 1 : 0);
            for (int i = 0; i < NK; i++) begin
                syn = !q2[i]; q2[i] = q1[i]; q1[i] = key_n[i];
                pr = 0; rl = 0;
                if (syn == lvl[i]) run[i] = 0;
                else if (tk) begin
                    run[i]++;
                    if (run[i] >= DEB) begin
                        lvl[i] = syn; run[i] = 0; pr = syn; rl = !syn;
                    end
                end
                el = t_now - ent[i];
                if (el > (1 << CW) - 1) el = (1 << CW) - 1;
                case (ph[i])
                    M_IDLE: if (pr) begin ph[i] = M_DOWN; ent[i] = tn; end
                    M_DOWN:
                        if (rl) begin ph[i] = M_WAIT; ent[i] = tn; end
                        else if (el == LMS) begin
                            m_l[i] = 1; ph[i] = M_HOLD; ent[i] = tn;
                        end
                    M_HOLD:
                        if (rl) begin ph[i] = M_IDLE; ent[i] = tn; end
`ifdef KEY_AUTO_REPEAT_EN
                        else if (el == RMS) begin m_r[i] = 1; ent[i] = tn; end
`endif
                    M_WAIT:
                        if (pr && el < DMS) begin
                            m_d[i] = 1; ph[i] = M_DOWN2; ent[i] = tn;
                        end else if (el == DMS) begin
                            m_s[i] = 1; ph[i] = M_IDLE; ent[i] = tn;
                        end
                    default: if (rl) begin ph[i] = M_IDLE; ent[i] = tn; end
                endcase
                m_lvl[i] = lvl[i];
            end
            t_now = tn;
        end
    end

    // Per-cycle observation: model agreement and event tallies.
    int         bad = 0;
    logic [4*NK+NK-1:0] last_got, last_exp;
    int         cnt_s[NK], cnt_d[NK], cnt_l[NK], cnt_r[NK], lvl_hi[NK];

    initial for (int i = 0; i < NK; i++) begin
        cnt_s[i] = 0; cnt_d[i] = 0; cnt_l[i] = 0; cnt_r[i] = 0; lvl_hi[i] = 0;
    end

    always @(negedge clk) if (!rst) begin
        if ({ev_single, ev_double, ev_long, ev_repeat, key_level} !==
            {m_s, m_d, m_l, m_r, m_lvl}) begin
            bad++;
            last_got = {ev_single, ev_double, ev_long, ev_repeat, key_level};
            last_exp = {m_s, m_d, m_l, m_r, m_lvl};
        end
        for (int i = 0; i < NK; i++) begin
            if ($countones({ev_single[i], ev_double[i], ev_long[i], ev_repeat[i]}) > 1)
                bad++;
            cnt_s[i] += int'(ev_single[i]);
            cnt_d[i] += int'(ev_double[i]);
            cnt_l[i] += int'(ev_long[i]);
            cnt_r[i] += int'(ev_repeat[i]);
            lvl_hi[i] += int'(key_level[i]);
        end
    end

    function automatic int evsum(int i);
        return cnt_s[i] + cnt_d[i] + cnt_l[i] + cnt_r[i];
    endfunction

    task automatic wait_clk(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int b, s0, h;
        rst = 1'b1; key_n = '1; key_n[0] = 1'b0;
        wait_clk(5);
        vectors++;
        if ({ev_single, ev_double, ev_long, ev_repeat, key_level} !== '0) begin
            $display("FAIL reset_outputs: got %b want 0",
                     {ev_single, ev_double, ev_long, ev_repeat, key_level});
            miscompares++;
        end
        b = bad; s0 = cnt_s[0];
        rst = 1'b0;
        h = $urandom_range(100, 200);
        wait_clk(h);
        vectors++;
        if (key_level[0] !== 1'b1) begin
            $display("FAIL reset_held_level: got %b want 1", key_level[0]);
            miscompares++;
        end
        key_n[0] = 1'b1;
        wait_clk(400);
        vectors++;
        if (cnt_s[0] - s0 !== 1) begin
            $display("FAIL reset_held_single: got %0d want 1", cnt_s[0] - s0);
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL reset_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_single();
        int b, s0, e0, e1;
        b = bad; s0 = cnt_s[0]; e0 = evsum(0); e1 = evsum(1);
        key_n[0] = 1'b0;
        wait_clk($urandom_range(150, 300));
        key_n[0] = 1'b1;
        wait_clk(400);
        vectors++;
        if (cnt_s[0] - s0 !== 1) begin
            $display("FAIL single_count: got %0d want 1", cnt_s[0] - s0);
            miscompares++;
        end
        vectors++;
        if ((evsum(0) - e0) + (evsum(1) - e1) !== 1) begin
            $display("FAIL single_other_events: got %0d total want 1",
                     (evsum(0) - e0) + (evsum(1) - e1));
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL single_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_double();
        int b, s0, d0, l0;
        b = bad; s0 = cnt_s[0]; d0 = cnt_d[0]; l0 = cnt_l[0];
        key_n[0] = 1'b0; wait_clk($urandom_range(80, 150));
        key_n[0] = 1'b1; wait_clk($urandom_range(60, 120));
        key_n[0] = 1'b0; wait_clk($urandom_range(80, 150));
        key_n[0] = 1'b1; wait_clk(400);
        vectors++;
        if (cnt_d[0] - d0 !== 1) begin
            $display("FAIL double_count: got %0d want 1", cnt_d[0] - d0);
            miscompares++;
        end
        vectors++;
        if ((cnt_s[0] - s0) + (cnt_l[0] - l0) !== 0) begin
            $display("FAIL double_no_single: got %0d want 0",
                     (cnt_s[0] - s0) + (cnt_l[0] - l0));
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL double_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_long();
        int b, l0, r0, e0, e1;
        b = bad; l0 = cnt_l[1]; r0 = cnt_r[1]; e0 = evsum(0); e1 = evsum(1);
        key_n[1] = 1'b0; wait_clk($urandom_range(700, 900));
        key_n[1] = 1'b1; wait_clk(300);
        vectors++;
        if (cnt_l[1] - l0 !== 1) begin
            $display("FAIL long_count: got %0d want 1", cnt_l[1] - l0);
            miscompares++;
        end
        vectors++;
        if ((evsum(1) - e1) - (cnt_l[1] - l0) - (cnt_r[1] - r0) !== 0 ||
            evsum(0) - e0 !== 0) begin
            $display("FAIL long_no_click: got %0d want 0",
                     (evsum(1) - e1) - (cnt_l[1] - l0) - (cnt_r[1] - r0));
            miscompares++;
        end
        vectors++;
`ifdef KEY_AUTO_REPEAT_EN
        if (cnt_r[1] - r0 < 1) begin
            $display("FAIL long_repeat: got %0d want >=1", cnt_r[1] - r0);
            miscompares++;
        end
`else
        if (cnt_r[1] - r0 !== 0) begin
            $display("FAIL long_repeat: got %0d want 0", cnt_r[1] - r0);
            miscompares++;
        end
`endif
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL long_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_bounce();
        int b, e0, h0, p;
        b = bad; e0 = evsum(0); h0 = lvl_hi[0];
        p = $urandom_range(3, 8);
        for (int t = 0; t < 60; t += p) begin
            key_n[0] = ~key_n[0];
            wait_clk(p);
        end
        key_n[0] = 1'b1;
        wait_clk(200);
        vectors++;
        if (lvl_hi[0] - h0 !== 0) begin
            $display("FAIL bounce_level: got %0d high cycles want 0", lvl_hi[0] - h0);
            miscompares++;
        end
        vectors++;
        if (evsum(0) - e0 !== 0) begin
            $display("FAIL bounce_events: got %0d want 0", evsum(0) - e0);
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL bounce_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        int b, s0, l1, e0, e1, r1;
        b = bad; s0 = cnt_s[0]; l1 = cnt_l[1]; r1 = cnt_r[1];
        e0 = evsum(0); e1 = evsum(1);
        key_n[1] = 1'b0; wait_clk($urandom_range(50, 150));
        key_n[0] = 1'b0; wait_clk($urandom_range(120, 200));
        key_n[0] = 1'b1; wait_clk(450);
        key_n[1] = 1'b1; wait_clk(300);
        vectors++;
        if (cnt_s[0] - s0 !== 1 || evsum(0) - e0 !== 1) begin
            $display("FAIL sim_key0: got %0d single %0d total want 1 1",
                     cnt_s[0] - s0, evsum(0) - e0);
            miscompares++;
        end
        vectors++;
        if (cnt_l[1] - l1 !== 1 || (evsum(1) - e1) - (cnt_r[1] - r1) !== 1) begin
            $display("FAIL sim_key1: got %0d long %0d total want 1 1",
                     cnt_l[1] - l1, (evsum(1) - e1) - (cnt_r[1] - r1));
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL sim_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int b, s0, d0, l0;
        b = bad; s0 = cnt_s[0]; d0 = cnt_d[0]; l0 = cnt_l[0];
        repeat (3) begin
            key_n[0] = 1'b0; wait_clk($urandom_range(70, 100));
            key_n[0] = 1'b1; wait_clk($urandom_range(70, 100));
        end
        wait_clk(400);
        vectors++;
        if (cnt_d[0] - d0 !== 1 || cnt_s[0] - s0 !== 1) begin
            $display("FAIL triple_click: got double %0d single %0d want 1 1",
                     cnt_d[0] - d0, cnt_s[0] - s0);
            miscompares++;
        end
        vectors++;
        if (cnt_l[0] - l0 !== 0) begin
            $display("FAIL triple_long: got %0d want 0", cnt_l[0] - l0);
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL triple_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_reset_gap();
        int b, e0, n;
        key_n[0] = 1'b0; wait_clk($urandom_range(120, 200));
        key_n[0] = 1'b1;
        n = 0;
        while (key_level[0] !== 1'b0 && n < 100) begin
            wait_clk(1);
            n++;
        end
        vectors++;
        if (key_level[0] !== 1'b0) begin
            $display("FAIL rgap_release_timeout: got %b want 0", key_level[0]);
            miscompares++;
        end
        wait_clk(3);
        rst = 1'b1;
        wait_clk(1);
        vectors++;
        if ({ev_single, ev_double, ev_long, ev_repeat, key_level} !== '0) begin
            $display("FAIL rgap_outputs: got %b want 0",
                     {ev_single, ev_double, ev_long, ev_repeat, key_level});
            miscompares++;
        end
        wait_clk(2);
        b = bad; e0 = evsum(0);
        rst = 1'b0;
        wait_clk(400);
        vectors++;
        if (evsum(0) - e0 !== 0) begin
            $display("FAIL rgap_no_event: got %0d want 0", evsum(0) - e0);
            miscompares++;
        end
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL rgap_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    task automatic test_random();
        int b, i;
        b = bad;
        repeat (40) begin
            i = $urandom_range(0, NK - 1);
            key_n[i] = ~key_n[i];
            wait_clk($urandom_range(5, 250));
        end
        key_n = '1;
        wait_clk(1200);
        vectors++;
        if (bad - b !== 0) begin
            $display("FAIL random_model: %0d bad cycles, last got %b want %b",
                     bad - b, last_got, last_exp);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_long();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_event_multi.md
Name: key_event_multi

Overview:
- Multi-channel key event decoder; successor to the single-key single/long/double-click block.
- Per key: 2-FF synchronizer, tick-based debounce, classifier FSM producing single/double/long click pulses.
- Shared millisecond prescaler; all timing is parametrised in milliseconds.
- Sits between board push-buttons (active-low) and control logic / LED toggles.

Parameters:
- NUM_KEYS, 4, number of independent key channels
- TICK_CYCLES, 24000, clk cycles per 1 ms tick (24 MHz)
- DEBOUNCE_MS, 20, ticks the raw level must differ from the stable level before it is accepted (min 1)
- LONG_MS, 2000, hold time that classifies a long press
- DCLICK_MS, 100, max release-to-press gap for a double click
- REPEAT_MS, 200, auto-repeat period (optional feature only)
- CNT_W, 12, per-key ms counter width; all *_MS values must be < 2^CNT_W

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_n  in  NUM_KEYS  raw keys, 0 = pressed, asynchronous
- ev_single  out  NUM_KEYS  1-cycle pulse per key: single click
- ev_double  out  NUM_KEYS  1-cycle pulse per key: double click
- ev_long  out  NUM_KEYS  1-cycle pulse per key: long press reached
- ev_repeat  out  NUM_KEYS  1-cycle pulse per key: auto-repeat (tied 0 without the feature)
- key_level  out  NUM_KEYS  debounced level, 1 = pressed

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: sync FFs and stable level = released; all FSMs IDLE; counters 0; all outputs 0. Reset mid-operation aborts with no event.
- Prescaler: counts 0..TICK_CYCLES-1; tick is high for 1 cycle at wrap. It is shared by all keys.
- Debounce, per key:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments on each tick.
  - When it reaches DEBOUNCE_MS, the stable level takes the synced level and the counter clears.
  - press / release are 1-cycle strobes on stable-level edges.
- A key held through reset release is reported as a press after debounce.
- The per-key ms counter clears on every state entry, increments on tick, and saturates at 2^CNT_W-1.
- FSM per key:
  - IDLE: press -> PRESS1.
  - PRESS1: release -> GAP. Counter == LONG_MS while held -> pulse ev_long, go to LONG.
  - LONG: release -> IDLE. No single/double is emitted.
  - GAP: press with counter < DCLICK_MS -> pulse ev_double, go to PRESS2. Counter == DCLICK_MS -> pulse ev_single, go to IDLE.
  - PRESS2: release -> IDLE. No long is detected in PRESS2.
- Simultaneous tick and press in GAP: press wins (double) if counter < DCLICK_MS before the increment.
- Triple or faster clicks give double, then a new sequence from IDLE.
- Event pulses are registered: high exactly 1 clk, the cycle after the FSM transition condition.
- At most one ev_* bit per key is high in any cycle. Keys are fully independent; simultaneous events on different keys are allowed.
- key_level reflects the stable level with 0 cycles of added latency beyond the debounce register.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - In LONG, the counter clears at ev_long and on each repeat.
  - Each time the counter reaches REPEAT_MS while held, ev_repeat pulses for 1 clk.
  - Release stops repeats immediately.
- Undefined: ev_repeat is constant 0, and no repeat counter logic is synthesized.

Test Plan:
(All scenarios use TICK_CYCLES=10, DEBOUNCE_MS=3, LONG_MS=50, DCLICK_MS=20, REPEAT_MS=10, NUM_KEYS=2.)
- Single click: key_n[0] low 200 clk, high -> exactly one ev_single[0] pulse ~20 ticks after debounced release; no other events.
- Double click: low 100 clk, high 100 clk, low 100 clk, high -> one ev_double[0] at the second debounced press; no ev_single[0].
- Long press: key_n[1] low 700 clk -> one ev_long[1] 50 ticks after debounced press; release gives no further event. With KEY_AUTO_REPEAT_EN: ev_repeat[1] every 100 clk until release.
- Bounce: key_n[0] toggles every 5 clk for 60 clk, then settles high -> key_level[0] stays 0 and no events occur.
- Simultaneous: key 0 single click while key 1 is long-pressed -> ev_single[0] and ev_long[1] both occur with correct timing and no cross-talk.
- Reset mid-GAP: assert rst 3 clk after the first release -> all outputs 0; no ev_single after rst deasserts.
